mem_test_ctrl: RTL and testbench
================================

Name: mem_test_ctrl

Overview:
Parametrised test-sequencing controller for the memory checker. It issues read/write commands over a valid/ready interface to the transmitter, and generates addresses internally from a base and a stride. Four test modes are supported. It counts comparator errors, optionally aborts on the first error, and reports completion once the transmitter, compare and measure blocks have drained. It sits between the CSR block and the transmitter, replacing the fixed-width single-pattern controller.

Parameters:
ADDR_W, 32, command address width
CNT_W, 16, transaction-count width
ERR_W, 16, error-counter width
TO_W, 20, drain-timeout counter width (used only with MEM_TEST_TIMEOUT_EN)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
start_i  in  1  start pulse; ignored unless idle
cfg_mode_i  in  2  0=READ_ONLY, 1=WRITE_ONLY, 2=WRITE_AND_CHECK, 3=BLOCK_WRITE_READ
cfg_count_i  in  CNT_W  number of transactions per phase minus 1
cfg_base_i  in  ADDR_W  first address
cfg_stride_i  in  ADDR_W  address increment
cfg_stop_on_err_i  in  1  abort the test on the first error
cmp_error_i  in  1  compare mismatch pulse
cmp_busy_i  in  1  compare block busy
meas_busy_i  in  1  measure block busy
trans_busy_i  in  1  transmitter busy
cmd_ready_i  in  1  transmitter accepts a command
cmd_valid_o  out  1  command valid
cmd_type_o  out  1  0=write, 1=read
cmd_addr_o  out  ADDR_W  command address
busy_o  out  1  test in progress
done_o  out  1  one-cycle completion pulse
fail_o  out  1  sticky: at least one error seen this test
err_cnt_o  out  ERR_W  saturating error count
timeout_o  out  1  drain timed out (tied 0 without the optional feature)

Behaviour:
- Reset values: every output is 0; state is IDLE; internal counters are 0.
- Reset mid-test returns all outputs to 0 immediately. No done_o is generated.
- Configuration inputs are sampled only on the start edge.
- Accept condition: cmd_valid_o && cmd_ready_i.
- While cmd_valid_o=1 and no accept has occurred, cmd_type_o and cmd_addr_o hold stable.
- States: IDLE, WR_ONLY, RD_ONLY, WR_WORD, RD_WORD, WR_BLOCK, RD_BLOCK, DRAIN.
- Start handling (IDLE with start_i=1), on the same edge:
  - state goes to WR_ONLY, RD_ONLY, WR_WORD or WR_BLOCK according to mode;
  - cmd_valid_o<=1, cmd_addr_o<=cfg_base_i, cmd_type_o set per state;
  - remaining count <= cfg_count_i; fail_o<=0; err_cnt_o<=0; timeout_o<=0; busy_o<=1.
  - Latency from start to the first valid command is 1 cycle.
- Address update: on a counted accept, cmd_addr_o <= cmd_addr_o + cfg_stride (mod 2^ADDR_W). Counted accepts are those in WR_ONLY, RD_ONLY, RD_WORD, WR_BLOCK and RD_BLOCK.
- WR_WORD: on accept, go to RD_WORD with type=read and the same address. No count decrement.
- RD_WORD: on accept, either decrement the count and go to WR_WORD, or, if it is the last transaction, go to DRAIN.
- WR_BLOCK: on the last accept, go to RD_BLOCK with cmd_addr_o<=base, type=read and count reloaded.
- RD_BLOCK, WR_ONLY, RD_ONLY: on the last accept, go to DRAIN.
- The last transaction is the one accepted when the remaining count is 0. cfg_count_i=0 therefore gives exactly one transaction per phase; all-ones gives 2^CNT_W transactions.
- cmd_valid_o stays 1 back-to-back across phase changes. It drops on the edge after the last accept, when entering DRAIN.
- DRAIN:
  - Starting the cycle after entry, when cmp_busy_i, meas_busy_i and trans_busy_i are all 0, go to IDLE.
  - done_o=1 for exactly one cycle on that edge; busy_o=0 on that edge.
- Errors:
  - cmp_error_i in any state other than IDLE sets fail_o and increments err_cnt_o, saturating at all-ones. Errors in IDLE are ignored.
  - If cfg_stop_on_err=1 in a command state: next state is DRAIN and cmd_valid_o<=0.
  - An accept in the same cycle as an error still counts, and its address updates, but no further command is issued.
  - With cfg_stop_on_err=0 the sequence continues unchanged.
- start_i while busy is ignored. start_i in the same cycle that done_o is generated is also ignored, because the state is not yet IDLE.

Optional Feature:
- Macro: MEM_TEST_TIMEOUT_EN.
- When defined:
  - A TO_W-bit counter clears on entry to DRAIN and increments each cycle spent in DRAIN.
  - If it reaches all-ones before the block drains, go to IDLE with done_o pulsed, timeout_o=1 (sticky until next start) and fail_o=1.
- When undefined: no counter is built, timeout_o is tied 0, and DRAIN waits indefinitely.

Test Plan:
1. WRITE_ONLY, count=3, base=0x100, stride=4, ready=1 -> four writes at 0x100/0x104/0x108/0x10C on consecutive cycles. Valid drops after the 4th. done_o pulses 1 cycle after busies are low; fail_o=0.
2. WRITE_AND_CHECK, count=1, base=0, stride=8, ready toggling 1/0 -> W0,R0,W8,R8 in order. Address and type hold while ready=0.
3. BLOCK_WRITE_READ, count=2, base=0xFFFFFFF8, stride=4 -> writes at FFFFFFF8, FFFFFFFC, 0 (wrap), then reads at the same three addresses. Valid is continuous across the phase change.
4. READ_ONLY, count=9, stop_on_err=0, three cmp_error_i pulses -> all 10 reads issued; err_cnt_o=3, fail_o=1.
5. WRITE_ONLY, count=9, stop_on_err=1, error coincident with the 3rd accept -> exactly 3 commands accepted, valid=0 next cycle. DRAIN waits for trans_busy_i to fall, then done_o.
6. Reset asserted mid-RD_WORD -> all outputs 0 asynchronously and no done_o. With MEM_TEST_TIMEOUT_EN and TO_W=4, cmp_busy_i stuck high -> done_o and timeout_o 15 cycles after DRAIN entry.

Source files
------------

// File: rtl/mem_test_ctrl.sv
// mem_test_ctrl: base/stride test sequencer issuing valid/ready commands, with error counting and drain tracking.
// Optional drain timeout is built when MEM_TEST_TIMEOUT_EN is defined.
module mem_test_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16,
  parameter int ERR_W  = 16,
  parameter int TO_W   = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        cfg_mode_i,
  input  logic [CNT_W-1:0]  cfg_count_i,
  input  logic [ADDR_W-1:0] cfg_base_i,
  input  logic [ADDR_W-1:0] cfg_stride_i,
  input  logic              cfg_stop_on_err_i,
  input  logic              cmp_error_i,
  input  logic              cmp_busy_i,
  input  logic              meas_busy_i,
  input  logic              trans_busy_i,
  input  logic              cmd_ready_i,
  output logic              cmd_valid_o,
  output logic              cmd_type_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic              timeout_o
);
  typedef enum logic [2:0] {IDLE, WR_ONLY, RD_ONLY, WR_WORD, RD_WORD, WR_BLOCK, RD_BLOCK, DRAIN} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] base, base_n, stride, stride_n, addr_n;
  logic [CNT_W-1:0] cnt, cnt_n, count, count_n;
  logic [ERR_W-1:0] err_n;
  logic stop, stop_n, valid_n, type_n, busy_n, done_n, fail_n;
  logic acc, last, err, drained, to_hit;
  assign acc = cmd_valid_o & cmd_ready_i;
  assign last = cnt == '0;
  assign err = cmp_error_i & (state != IDLE);
  assign drained = ~(cmp_busy_i | meas_busy_i | trans_busy_i);
`ifdef MEM_TEST_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt, to_inc;
  assign to_inc = to_cnt + 1'b1;
  // fires on the edge where the counter would reach all-ones
  assign to_hit = (state == DRAIN) & (&to_inc);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt <= '0;
      timeout_o <= 1'b0;
    end else begin
      to_cnt <= (state == DRAIN) ? to_inc : '0;
      if (state == IDLE && start_i) timeout_o <= 1'b0;
      else if (to_hit && !drained) timeout_o <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
  assign timeout_o = 1'b0;
`endif
  always_comb begin
    state_n = state;
    valid_n = cmd_valid_o;
    type_n = cmd_type_o;
    addr_n = cmd_addr_o;
    cnt_n = cnt;
    count_n = count;
    base_n = base;
    stride_n = stride;
    stop_n = stop;
    busy_n = busy_o;
    done_n = 1'b0;
    fail_n = fail_o | err;
    err_n = (err && !(&err_cnt_o)) ? err_cnt_o + 1'b1 : err_cnt_o;
    case (state)
      IDLE: if (start_i) begin
        state_n = cfg_mode_i == 2'd0 ? RD_ONLY : cfg_mode_i == 2'd1 ? WR_ONLY :
                  cfg_mode_i == 2'd2 ? WR_WORD : WR_BLOCK;
        valid_n = 1'b1;
        type_n = cfg_mode_i == 2'd0;
        addr_n = cfg_base_i;
        cnt_n = cfg_count_i;
        count_n = cfg_count_i;
        base_n = cfg_base_i;
        stride_n = cfg_stride_i;
        stop_n = cfg_stop_on_err_i;
        busy_n = 1'b1;
        fail_n = 1'b0;
        err_n = '0;
      end
      DRAIN: if (drained || to_hit) begin
        state_n = IDLE;
        done_n = 1'b1;
        busy_n = 1'b0;
        fail_n = fail_o | err | !drained;
      end
      default: begin
        if (acc) begin
          if (state != WR_WORD) addr_n = cmd_addr_o + stride;
          if (state == WR_WORD) begin
            state_n = RD_WORD;
            type_n = 1'b1;
          end else if (!last) begin
            cnt_n = cnt - 1'b1;
            if (state == RD_WORD) begin
              state_n = WR_WORD;
              type_n = 1'b0;
            end
          end else if (state == WR_BLOCK) begin
            state_n = RD_BLOCK;
            type_n = 1'b1;
            addr_n = base;
            cnt_n = count;
          end else begin
            state_n = DRAIN;
            valid_n = 1'b0;
          end
        end
        // an accepted command still advances the address before the abort
        if (err && stop) begin
          state_n = DRAIN;
          valid_n = 1'b0;
        end
      end
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cmd_valid_o <= 1'b0;
      cmd_type_o <= 1'b0;
      cmd_addr_o <= '0;
      cnt <= '0;
      count <= '0;
      base <= '0;
      stride <= '0;
      stop <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      fail_o <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      state <= state_n;
      cmd_valid_o <= valid_n;
      cmd_type_o <= type_n;
      cmd_addr_o <= addr_n;
      cnt <= cnt_n;
      count <= count_n;
      base <= base_n;
      stride <= stride_n;
      stop <= stop_n;
      busy_o <= busy_n;
      done_o <= done_n;
      fail_o <= fail_n;
      err_cnt_o <= err_n;
    end
  end
endmodule

// File: tb/tb_mem_test_ctrl.sv
// tb_mem_test_ctrl: directed checks of mem_test_ctrl sequencing, errors, drain and reset.
module tb_mem_test_ctrl;
  logic clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0;
  logic [1:0] cfg_mode_i = '0;
  logic [15:0] cfg_count_i = '0;
  logic [31:0] cfg_base_i = '0, cfg_stride_i = '0;
  logic cfg_stop_on_err_i = 1'b0, cmp_error_i = 1'b0, cmp_busy_i = 1'b0;
  logic meas_busy_i = 1'b0, trans_busy_i = 1'b0, cmd_ready_i = 1'b0;
  logic cmd_valid_o, cmd_type_o, busy_o, done_o, fail_o, timeout_o;
  logic [31:0] cmd_addr_o;
  logic [15:0] err_cnt_o;
  int checks = 0, passed = 0;
  logic [31:0] exp3 [6];

  mem_test_ctrl #(.TO_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .cfg_mode_i(cfg_mode_i),
    .cfg_count_i(cfg_count_i), .cfg_base_i(cfg_base_i), .cfg_stride_i(cfg_stride_i),
    .cfg_stop_on_err_i(cfg_stop_on_err_i), .cmp_error_i(cmp_error_i), .cmp_busy_i(cmp_busy_i),
    .meas_busy_i(meas_busy_i), .trans_busy_i(trans_busy_i), .cmd_ready_i(cmd_ready_i),
    .cmd_valid_o(cmd_valid_o), .cmd_type_o(cmd_type_o), .cmd_addr_o(cmd_addr_o),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .err_cnt_o(err_cnt_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic start_test(input logic [1:0] m, input logic [15:0] c, input logic [31:0] b,
                            input logic [31:0] s, input logic stop);
    cfg_mode_i = m;
    cfg_count_i = c;
    cfg_base_i = b;
    cfg_stride_i = s;
    cfg_stop_on_err_i = stop;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    exp3 = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0};
    repeat (2) tick();
    chk("rst valid", cmd_valid_o, 1'b0);
    chk("rst busy", busy_o, 1'b0);
    chk("rst addr", cmd_addr_o, 0);
    chk("rst err", err_cnt_o, 0);
    rst_i = 1'b0;
    tick();
    chk("idle done", done_o, 1'b0);
    // write-only streaming
    cmd_ready_i = 1'b1;
    start_test(2'd1, 16'd3, 32'h100, 32'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t1 valid", cmd_valid_o, 1'b1);
      chk("t1 type", cmd_type_o, 1'b0);
      chk("t1 addr", cmd_addr_o, 32'h100 + 4 * i);
      chk("t1 busy", busy_o, 1'b1);
      tick();
    end
    chk("t1 valid drop", cmd_valid_o, 1'b0);
    chk("t1 busy drain", busy_o, 1'b1);
    chk("t1 no early done", done_o, 1'b0);
    tick();
    chk("t1 done", done_o, 1'b1);
    chk("t1 busy end", busy_o, 1'b0);
    chk("t1 fail", fail_o, 1'b0);
    chk("t1 timeout", timeout_o, 1'b0);
    tick();
    chk("t1 done once", done_o, 1'b0);
    cmp_error_i = 1'b1;
    tick();
    cmp_error_i = 1'b0;
    chk("idle err fail", fail_o, 1'b0);
    chk("idle err cnt", err_cnt_o, 0);
    // write-and-check with ready toggling
    cmd_ready_i = 1'b0;
    start_test(2'd2, 16'd1, 32'h0, 32'd8, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("t2 valid", cmd_valid_o, 1'b1);
      chk("t2 type", cmd_type_o, k % 2);
      chk("t2 addr", cmd_addr_o, (k / 2) * 8);
      cmd_ready_i = 1'b0;
      tick();
      chk("t2 hold type", cmd_type_o, k % 2);
      chk("t2 hold addr", cmd_addr_o, (k / 2) * 8);
      cmd_ready_i = 1'b1;
      tick();
    end
    chk("t2 valid drop", cmd_valid_o, 1'b0);
    tick();
    chk("t2 done", done_o, 1'b1);
    // block write then read with address wrap
    start_test(2'd3, 16'd2, 32'hFFFFFFF8, 32'd4, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("t3 valid", cmd_valid_o, 1'b1);
      chk("t3 type", cmd_type_o, i >= 3);
      chk("t3 addr", cmd_addr_o, exp3[i]);
      tick();
    end
    chk("t3 valid drop", cmd_valid_o, 1'b0);
    tick();
    chk("t3 done", done_o, 1'b1);
    // read-only with errors, no abort
    start_test(2'd0, 16'd9, 32'h2000, 32'h10, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("t4 valid", cmd_valid_o, 1'b1);
      chk("t4 type", cmd_type_o, 1'b1);
      chk("t4 addr", cmd_addr_o, 32'h2000 + 16 * i);
      cmp_error_i = (i == 2 || i == 5 || i == 7);
      tick();
    end
    cmp_error_i = 1'b0;
    chk("t4 valid drop", cmd_valid_o, 1'b0);
    chk("t4 err cnt", err_cnt_o, 3);
    chk("t4 fail", fail_o, 1'b1);
    tick();
    chk("t4 done", done_o, 1'b1);
    chk("t4 fail sticky", fail_o, 1'b1);
    // stop on error coincident with third accept, drain held by transmitter
    trans_busy_i = 1'b1;
    start_test(2'd1, 16'd9, 32'h40, 32'd1, 1'b1);
    chk("t5 fail clr", fail_o, 1'b0);
    chk("t5 err clr", err_cnt_o, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t5 valid", cmd_valid_o, 1'b1);
      chk("t5 addr", cmd_addr_o, 32'h40 + i);
      cmp_error_i = (i == 2);
      tick();
    end
    cmp_error_i = 1'b0;
    chk("t5 valid drop", cmd_valid_o, 1'b0);
    chk("t5 addr adv", cmd_addr_o, 32'h43);
    chk("t5 fail", fail_o, 1'b1);
    chk("t5 err cnt", err_cnt_o, 1);
    start_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5 drain wait", done_o, 1'b0);
      chk("t5 drain busy", busy_o, 1'b1);
      chk("t5 start ignored", cmd_valid_o, 1'b0);
    end
    trans_busy_i = 1'b0;
    tick();
    chk("t5 done", done_o, 1'b1);
    chk("t5 busy end", busy_o, 1'b0);
    start_i = 1'b0;
    tick();
    chk("t5 start at done ignored", cmd_valid_o, 1'b0);
    chk("t5 still idle", busy_o, 1'b0);
    // asynchronous reset in the read half of a word pair
    start_test(2'd2, 16'd3, 32'h80, 32'd4, 1'b0);
    tick();
    chk("t6 rd type", cmd_type_o, 1'b1);
    chk("t6 rd addr", cmd_addr_o, 32'h80);
    #2 rst_i = 1'b1;
    #1;
    chk("t6 valid", cmd_valid_o, 1'b0);
    chk("t6 type", cmd_type_o, 1'b0);
    chk("t6 addr", cmd_addr_o, 0);
    chk("t6 busy", busy_o, 1'b0);
    chk("t6 done", done_o, 1'b0);
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6 no done", done_o, 1'b0);
      chk("t6 no cmd", cmd_valid_o, 1'b0);
    end
`ifdef MEM_TEST_TIMEOUT_EN
    cmp_busy_i = 1'b1;
    start_test(2'd1, 16'd0, 32'h0, 32'd1, 1'b0);
    tick();
    chk("to drain", cmd_valid_o, 1'b0);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("to wait", done_o, 1'b0);
    end
    tick();
    chk("to done", done_o, 1'b1);
    chk("to flag", timeout_o, 1'b1);
    chk("to fail", fail_o, 1'b1);
    cmp_busy_i = 1'b0;
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
